// File: rtl/input_debounce_pkg.sv
// Shared types and helpers for the input_debounce block.
//   state_t : per-channel debounce FSM encoding (2-bit)
//   cnt_w   : width of a counter that must hold values 0..dt
package input_debounce_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ARM_ON  = 2'd1,
    ON      = 2'd2,
    ARM_OFF = 2'd3
  } state_t;

  function automatic int cnt_w(input int dt);
    return (dt < 1) ? 1 : $clog2(dt + 1);
  endfunction

endpackage

// File: rtl/input_debounce_ch.sv
// Single-channel debouncer: synchroniser, tick-qualified stability counter,
// debounce FSM and (optionally) autorepeat on press.
// Optional autorepeat is built only when INPUT_DEBOUNCE_REPEAT_EN is defined.
// Ports:
//   clk    in  system clock
//   rst_n  in  async active-low reset
//   tick   in  sample enable for the stability/repeat counters
//   i      in  raw asynchronous input
//   o      out debounced level, 1 = on
//   press  out one-clk pulse on off->on (plus repeats when enabled)
//   rel    out one-clk pulse on on->off ("release" is a reserved word)
//
// state   | meaning
// OFF     | output off, counter cleared
// ARM_ON  | on-level sampled, counting ticks of stable on-level
// ON      | output on
// ARM_OFF | off-level sampled, counting ticks of stable off-level
module input_debounce_ch
  import input_debounce_pkg::*;
#(
  parameter logic DS = 1'b0,
  parameter int   DT = 10,
  parameter int   SN = 2
`ifdef INPUT_DEBOUNCE_REPEAT_EN
  ,
  parameter int   RD = 50,
  parameter int   RP = 10
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic i,
  output logic o,
  output logic press,
  output logic rel
);

  localparam int CW = cnt_w(DT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DT - 1);

  logic [SN-1:0] sync;
  logic          s;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          o_nx, press_nx, rel_nx, press_d;

  assign s = sync[SN-1] ^ DS;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    o_nx     = o;
    press_nx = 1'b0;
    rel_nx   = 1'b0;
    case (state)
      OFF: begin
        cnt_nx = '0;
        if (s) state_nx = ARM_ON;
      end
      ARM_ON: begin
        if (!s) begin
          state_nx = OFF;
          cnt_nx   = '0;
        end else if (tick) begin
          if (cnt == CNT_LAST) begin
            state_nx = ON;
            cnt_nx   = '0;
            o_nx     = 1'b1;
            press_nx = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      ON: begin
        cnt_nx = '0;
        if (!s) state_nx = ARM_OFF;
      end
      ARM_OFF: begin
        if (s) begin
          state_nx = ON;
          cnt_nx   = '0;
        end else if (tick) begin
          if (cnt == CNT_LAST) begin
            state_nx = OFF;
            cnt_nx   = '0;
            o_nx     = 1'b0;
            rel_nx   = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nx = OFF;
        cnt_nx   = '0;
        o_nx     = 1'b0;
      end
    endcase
  end

`ifdef INPUT_DEBOUNCE_REPEAT_EN
  localparam int RW = cnt_w((RD > RP) ? RD : RP);
  localparam logic [RW-1:0] REP_FIRST = RW'(RD - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(RP - 1);

  logic [RW-1:0] rcnt, rcnt_nx;
  logic          rphase, rphase_nx, rep_hit;

  // Counting only while ON with the on-level still present, so ARM_OFF
  // freezes the count and a bounce back to ON resumes where it left off.
  always_comb begin
    rcnt_nx   = rcnt;
    rphase_nx = rphase;
    rep_hit   = 1'b0;
    if (state_nx == OFF) begin
      rcnt_nx   = '0;
      rphase_nx = 1'b0;
    end else if (state == ON && s && tick) begin
      if (rcnt == (rphase ? REP_NEXT : REP_FIRST)) begin
        rep_hit   = 1'b1;
        rcnt_nx   = '0;
        rphase_nx = 1'b1;
      end else begin
        rcnt_nx = rcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt   <= '0;
      rphase <= 1'b0;
    end else begin
      rcnt   <= rcnt_nx;
      rphase <= rphase_nx;
    end
  end

  assign press_d = press_nx | rep_hit;
`else
  assign press_d = press_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= {SN{DS}};
      state <= OFF;
      cnt   <= '0;
      o     <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync  <= {sync[SN-2:0], i};
      state <= state_nx;
      cnt   <= cnt_nx;
      o     <= o_nx;
      press <= press_d;
      rel   <= rel_nx;
    end
  end

endmodule

// File: rtl/input_debounce.sv
// Multi-channel button/switch debouncer: IW independent channels, each
// synchronised, debounced and polarity-normalised (1 = on).
// Optional autorepeat is built only when INPUT_DEBOUNCE_REPEAT_EN is defined.
// Ports:
//   clk    in  system clock
//   rst_n  in  async active-low reset
//   tick   in  sample enable (tie to 1 to count in clocks)
//   i      in  [IW] raw asynchronous inputs
//   o      out [IW] debounced levels
//   press  out [IW] one-clk off->on strobes
//   rel    out [IW] one-clk on->off strobes ("release" is a reserved word)
module input_debounce #(
  parameter int   IW = 1,
  parameter logic DS = 1'b0,
  parameter int   DT = 10,
  parameter int   SN = 2
`ifdef INPUT_DEBOUNCE_REPEAT_EN
  ,
  parameter int   RD = 50,
  parameter int   RP = 10
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic [IW-1:0] i,
  output logic [IW-1:0] o,
  output logic [IW-1:0] press,
  output logic [IW-1:0] rel
);

  for (genvar g = 0; g < IW; g++) begin : g_ch
    input_debounce_ch #(
      .DS(DS),
      .DT(DT),
      .SN(SN)
`ifdef INPUT_DEBOUNCE_REPEAT_EN
      ,
      .RD(RD),
      .RP(RP)
`endif
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .i    (i[g]),
      .o    (o[g]),
      .press(press[g]),
      .rel  (rel[g])
    );
  end

endmodule

// File: tb/tb_input_debounce.sv
module tb_input_debounce;

  logic       clk;
  logic       rst_n;
  logic [1:0] i_a, o_a, press_a, rel_a;
  logic       i_b, o_b, press_b, rel_b;
  logic       i_c, o_c, press_c, rel_c;
  logic       tick_c;
  int         tph;
  int         errs;
  int         checks;

  input_debounce #(.IW(2), .DS(1'b0), .DT(4), .SN(2)
`ifdef INPUT_DEBOUNCE_REPEAT_EN
    , .RD(5), .RP(2)
`endif
  ) u_a (.clk(clk), .rst_n(rst_n), .tick(1'b1), .i(i_a), .o(o_a), .press(press_a), .rel(rel_a));

  input_debounce #(.IW(1), .DS(1'b1), .DT(4), .SN(2)
`ifdef INPUT_DEBOUNCE_REPEAT_EN
    , .RD(5), .RP(2)
`endif
  ) u_b (.clk(clk), .rst_n(rst_n), .tick(1'b1), .i(i_b), .o(o_b), .press(press_b), .rel(rel_b));

  input_debounce #(.IW(1), .DS(1'b0), .DT(3), .SN(2)
`ifdef INPUT_DEBOUNCE_REPEAT_EN
    , .RD(5), .RP(2)
`endif
  ) u_c (.clk(clk), .rst_n(rst_n), .tick(tick_c), .i(i_c), .o(o_c), .press(press_c), .rel(rel_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // tick for u_c: high for one clk out of every 8
  initial begin
    tph = 0;
    tick_c = 1'b0;
    forever begin
      @(negedge clk);
      tph = (tph + 1) % 8;
      tick_c = (tph == 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_a = 2'b00;
    i_b = 1'b1;
    i_c = 1'b0;
    repeat (3) step();
    checks++;
    if ({o_a, press_a, rel_a, o_b, press_b, rel_b, o_c, press_c, rel_c} !== 12'b0) begin
      errs++;
      $display("FAIL reset_state: got %b expected 0", {o_a, press_a, rel_a, o_b, press_b, rel_b, o_c, press_c, rel_c});
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if ({o_a, press_a, rel_a, o_b, press_b, rel_b, o_c, press_c, rel_c} !== 12'b0) begin
        errs++;
        $display("FAIL reset_release_quiet k=%0d: got %b expected 0", k, {o_a, press_a, rel_a, o_b, press_b, rel_b, o_c, press_c, rel_c});
      end
    end
  endtask

  task automatic test_clean_press();
    i_a[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if ({o_a[0], press_a[0], rel_a[0], o_a[1]} !== {(k >= 7), (k == 7), 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL clean_press k=%0d: got o/press/rel/o1=%b expected %b", k, {o_a[0], press_a[0], rel_a[0], o_a[1]}, {(k >= 7), (k == 7), 1'b0, 1'b0});
      end
    end
    repeat (90) step();
    i_a[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if ({o_a[0], rel_a[0]} !== {(k < 7), (k == 7)} || (k >= 3 && press_a[0] !== 1'b0)) begin
        errs++;
        $display("FAIL clean_release k=%0d: got o/rel/press=%b%b%b expected o/rel=%b%b press=0", k, o_a[0], rel_a[0], press_a[0], (k < 7), (k == 7));
      end
    end
  endtask

  task automatic test_bounce();
    int npress;
    npress = 0;
    for (int k = 1; k <= 15; k++) begin
      i_a[0] = (k <= 5) ? k[0] : 1'b1;
      step();
      if (press_a[0] === 1'b1) npress++;
      checks++;
      if ({o_a[0], press_a[0]} !== {(k >= 11), (k == 11)}) begin
        errs++;
        $display("FAIL bounce k=%0d: got o/press=%b expected %b", k, {o_a[0], press_a[0]}, {(k >= 11), (k == 11)});
      end
    end
    checks++;
    if (npress != 1) begin
      errs++;
      $display("FAIL bounce_press_count: got %0d expected 1", npress);
    end
    i_a[0] = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_active_low();
    i_b = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if ({o_b, press_b, rel_b} !== {(k >= 7), (k == 7), 1'b0}) begin
        errs++;
        $display("FAIL active_low_press k=%0d: got %b expected %b", k, {o_b, press_b, rel_b}, {(k >= 7), (k == 7), 1'b0});
      end
    end
    i_b = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if ({o_b, rel_b} !== {(k < 7), (k == 7)}) begin
        errs++;
        $display("FAIL active_low_release k=%0d: got o/rel=%b expected %b", k, {o_b, rel_b}, {(k < 7), (k == 7)});
      end
    end
  endtask

  task automatic test_simultaneous();
    i_a = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if ({o_a, press_a} !== {((k >= 7) ? 2'b11 : 2'b00), ((k == 7) ? 2'b11 : 2'b00)}) begin
        errs++;
        $display("FAIL simul_press k=%0d: got o/press=%b expected %b", k, {o_a, press_a}, {((k >= 7) ? 2'b11 : 2'b00), ((k == 7) ? 2'b11 : 2'b00)});
      end
    end
    i_a = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if ({o_a, rel_a, press_a} !== {((k < 7) ? 2'b11 : 2'b00), ((k == 7) ? 2'b11 : 2'b00), 2'b00}) begin
        errs++;
        $display("FAIL simul_release k=%0d: got o/rel/press=%b expected %b", k, {o_a, rel_a, press_a}, {((k < 7) ? 2'b11 : 2'b00), ((k == 7) ? 2'b11 : 2'b00), 2'b00});
      end
    end
  endtask

  task automatic align_tick();
    int n;
    n = 0;
    while (tph != 7 && n < 16) begin
      step();
      n++;
    end
    checks++;
    if (tph != 7) begin
      errs++;
      $display("FAIL tick_align: got phase %0d expected 7", tph);
    end
  endtask

  task automatic test_tick_gating();
    // glitch of 5 clocks between ticks restarts the count
    align_tick();
    for (int k = 1; k <= 41; k++) begin
      i_c = (k >= 11 && k <= 15) ? 1'b0 : 1'b1;
      step();
      checks++;
      if ({o_c, press_c} !== {(k == 41), (k == 41)}) begin
        errs++;
        $display("FAIL tick_glitch k=%0d: got o/press=%b expected %b", k, {o_c, press_c}, {(k == 41), (k == 41)});
      end
    end
    i_c = 1'b0;
    repeat (40) step();
    checks++;
    if (o_c !== 1'b0) begin
      errs++;
      $display("FAIL tick_release: got o=%b expected 0", o_c);
    end
    // clean edge commits on the 3rd tick after synchronisation
    align_tick();
    i_c = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      step();
      checks++;
      if ({o_c, press_c} !== {(k >= 25), (k == 25)}) begin
        errs++;
        $display("FAIL tick_clean k=%0d: got o/press=%b expected %b", k, {o_c, press_c}, {(k >= 25), (k == 25)});
      end
    end
    i_c = 1'b0;
    repeat (40) step();
  endtask

  task automatic test_autorepeat();
    logic exp_p;
    i_a[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
`ifdef INPUT_DEBOUNCE_REPEAT_EN
      exp_p = (k == 7) || (k >= 12 && ((k - 12) % 2) == 0);
`else
      exp_p = (k == 7);
`endif
      checks++;
      if (press_a[0] !== exp_p) begin
        errs++;
        $display("FAIL autorepeat k=%0d: got press=%b expected %b", k, press_a[0], exp_p);
      end
    end
    i_a[0] = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_reset_mid();
    i_a[0] = 1'b1;
    repeat (8) step();
    i_a[0] = 1'b0;
    repeat (4) step();
    checks++;
    if (o_a[0] !== 1'b1) begin
      errs++;
      $display("FAIL mid_arm_off_level: got o=%b expected 1", o_a[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_a[0], rel_a[0]} !== 2'b00) begin
      errs++;
      $display("FAIL mid_async_clear: got o/rel=%b expected 00", {o_a[0], rel_a[0]});
    end
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if ({o_a, press_a, rel_a} !== 6'b0) begin
        errs++;
        $display("FAIL mid_no_strobe k=%0d: got %b expected 0", k, {o_a, press_a, rel_a});
      end
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    rst_n = 1'b0;
    i_a = 2'b00;
    i_b = 1'b1;
    i_c = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_active_low();
    test_simultaneous();
    test_tick_gating();
    test_autorepeat();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
